ram_port_arbiter: RTL and testbench

Shares one port of the dual-port block RAM between the core's instruction-fetch unit and load/store unit. Each cycle it grants at most one requester and drives the RAM port. It returns the read data one cycle later, formatted for the access size. Stores are converted to byte-lane enables, and misaligned data accesses are rejected without touching memory. Data accesses normally win; a starvation counter guarantees that fetch still makes forward progress.

---
 rtl/ucrv_mem_pkg.sv | 42 ++++
 rtl/mem_load_align.sv | 26 ++
 rtl/ram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ucrv_mem_pkg.sv
// Shared types and helpers for the instruction/data RAM port arbiter.
// Holds access-size and owner encodings plus the store lane and alignment helpers.
package ucrv_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic {
    PRIO_DATA  = 1'b0,
    PRIO_FETCH = 1'b1
  } prio_state_e;

  // Byte offset k of the access maps to enable bit 3-k.
  function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] off);
    logic [2:0] nbytes;
    logic [3:0] we;
    case (size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    we = '0;
    for (int k = 0; k < 4; k++) begin
      if ((3'(k) >= {1'b0, off}) && (3'(k) < ({1'b0, off} + nbytes))) we[3-k] = 1'b1;
    end
    return we;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) || ((size == 2'b10) && (off != 2'b00)) || ((size == 2'b01) && off[0]);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts a byte/halfword from a RAM word at the given byte offset and
// sign- or zero-extends it; words pass through unchanged.
module mem_load_align
  import ucrv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  mem_size_e   size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = rdata;
    case (size)
      BYTE:    data = uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      HALF:    data = uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates one block-RAM port between instruction fetch and load/store,
// with a starvation counter that periodically hands priority to fetch.
//
// state      | meaning
// PRIO_DATA  | data wins a contested cycle (reset state)
// PRIO_FETCH | fetch starved STARVE_LIMIT times; fetch wins until granted
module ram_port_arbiter
  import ucrv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [31:0]           if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [1:0]            d_size_i,
  input  logic                  d_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]           d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [31:0]           d_rdata_o,
  output logic                  d_misaligned_o,
  output logic                  ram_en_o,
  output logic [3:0]            ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  prio_state_e   state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          d_mis;

  logic          r_valid, r_uns, r_mis, r_we;
  owner_e        r_owner;
  logic [1:0]    r_size, r_off;
  logic [31:0]   load_data;

  assign d_mis = is_misaligned(d_size_i, d_addr_i[1:0]);

  always_comb begin
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    state_d     = state_q;
    starve_d    = starve_q;
    ram_en_o    = 1'b0;
    ram_we_o    = 4'b0000;
    ram_addr_o  = '0;
    ram_wdata_o = '0;

    if (!rst_i) begin
      if (state_q == PRIO_DATA) begin
        if (d_req_i)       d_gnt_o  = 1'b1;
        else if (if_req_i) if_gnt_o = 1'b1;
      end else begin
        if (if_req_i)      if_gnt_o = 1'b1;
        else if (d_req_i)  d_gnt_o  = 1'b1;
      end
    end

    if (if_gnt_o)                                      starve_d = '0;
    else if (d_gnt_o && if_req_i && (starve_q != LIM)) starve_d = starve_q + 1'b1;

    // Switch on the count being reached this cycle so the fetch wins the very next cycle.
    case (state_q)
      PRIO_DATA:  if (starve_d == LIM) state_d = PRIO_FETCH;
      PRIO_FETCH: if (if_gnt_o)        state_d = PRIO_DATA;
      default:                         state_d = PRIO_DATA;
    endcase

    if (if_gnt_o) begin
      ram_en_o   = 1'b1;
      ram_addr_o = if_addr_i & ~ADDR_WIDTH'(3);
    end else if (d_gnt_o && !d_mis) begin
      ram_en_o   = 1'b1;
      ram_addr_o = d_addr_i;
      if (d_we_i) begin
        ram_we_o = lane_we(d_size_i, d_addr_i[1:0]);
        case (d_size_i)
          2'b00:   ram_wdata_o = {4{d_wdata_i[7:0]}};
          2'b01:   ram_wdata_o = {2{d_wdata_i[15:0]}};
          default: ram_wdata_o = d_wdata_i;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= PRIO_DATA;
      starve_q <= '0;
      r_valid  <= 1'b0;
      r_owner  <= OWN_IF;
      r_size   <= 2'b00;
      r_off    <= 2'b00;
      r_uns    <= 1'b0;
      r_mis    <= 1'b0;
      r_we     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      r_valid  <= if_gnt_o | d_gnt_o;
      r_owner  <= d_gnt_o ? OWN_D : OWN_IF;
      r_size   <= d_size_i;
      r_off    <= d_addr_i[1:0];
      r_uns    <= d_unsigned_i;
      r_mis    <= d_gnt_o & d_mis;
      r_we     <= d_gnt_o & d_we_i;
    end
  end

  mem_load_align u_load_align (
    .rdata  (ram_rdata_i),
    .offset (r_off),
    .size   (mem_size_e'(r_size)),
    .uns    (r_uns),
    .data   (load_data)
  );

  // Gating with rst_i drops a response that is still on the outputs when reset arrives.
  assign if_rvalid_o    = r_valid && (r_owner == OWN_IF) && !rst_i;
  assign d_rvalid_o     = r_valid && (r_owner == OWN_D) && !rst_i;
  assign d_misaligned_o = d_rvalid_o && r_mis;
  assign if_rdata_o     = if_rvalid_o ? ram_rdata_i : 32'b0;
  assign d_rdata_o      = (d_rvalid_o && !r_mis && !r_we) ? load_data : 32'b0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios then held random requests,
// checked against a byte-array memory and a fetch-loss counter model.
module tb_ram_port_arbiter;

  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_i, if_req_i, d_req_i, d_we_i, d_unsigned_i;
  logic [AW-1:0] if_addr_i, d_addr_i, ram_addr_o;
  logic [1:0]    d_size_i;
  logic [31:0]   d_wdata_i, if_rdata_o, d_rdata_o, ram_wdata_o, ram_rdata_i;
  logic          if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, d_misaligned_o, ram_en_o;
  logic [3:0]    ram_we_o;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i), .d_unsigned_i(d_unsigned_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_misaligned_o(d_misaligned_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  // Block RAM: one-cycle read latency, byte offset k written when ram_we_o[3-k].
  logic [31:0] ramw [64];
  logic        tb_clr;
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 64; i++) ramw[i] <= '0;
      ram_rdata_i <= '0;
    end else if (ram_en_o) begin
      ram_rdata_i <= ramw[ram_addr_o[7:2]];
      for (int k = 0; k < 4; k++)
        if (ram_we_o[3-k]) ramw[ram_addr_o[7:2]][8*k +: 8] <= ram_wdata_o[8*k +: 8];
    end
  end

  logic [7:0]  mem_b [256];
  int          losses, n_assert, n_fail;
  logic        exp_ifv, exp_dv, exp_mis;
  logic [31:0] exp_ifd, exp_dd, obs_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [1:0] ds, input logic du,
                     input logic [31:0] da, input logic [31:0] dwd);
    logic gi, gd, mis, en_e;
    int nb;
    logic [31:0] v, wd_e, ad_e;
    logic [3:0] we_e;
    logic [7:0] bi;
    @(negedge clk);
    rst_i = r; if_req_i = ir; if_addr_i = ia; d_req_i = dr; d_we_i = dw;
    d_size_i = ds; d_unsigned_i = du; d_addr_i = da; d_wdata_i = dwd;
    #1;
    if (r) begin exp_ifv = 0; exp_dv = 0; exp_mis = 0; exp_ifd = 0; exp_dd = 0; end
    chk("if_rvalid", 32'(if_rvalid_o), 32'(exp_ifv));
    chk("if_rdata", if_rdata_o, exp_ifd);
    chk("d_rvalid", 32'(d_rvalid_o), 32'(exp_dv));
    chk("d_rdata", d_rdata_o, exp_dd);
    chk("d_misaligned", 32'(d_misaligned_o), 32'(exp_mis));
    obs_d = d_rdata_o;

    gi  = !r && ir && (!dr || losses >= LIMIT);
    gd  = !r && dr && !gi;
    mis = (ds == 2'd3) || (ds == 2'd2 && da[1:0] != 2'd0) || (ds == 2'd1 && da[0]);
    nb  = 1 << ds;
    chk("if_gnt", 32'(if_gnt_o), 32'(gi));
    chk("d_gnt", 32'(d_gnt_o), 32'(gd));
    chk("gnt_excl", 32'(if_gnt_o & d_gnt_o), 32'd0);

    en_e = 0; we_e = 0; wd_e = 0; ad_e = 0;
    if (gi) begin
      en_e = 1; ad_e = ia & ~32'h3;
    end else if (gd && !mis) begin
      en_e = 1; ad_e = da;
      if (dw) begin
        for (int i = 0; i < nb; i++) we_e[3 - (int'(da[1:0]) + i)] = 1'b1;
        for (int k = 0; k < 4; k++) wd_e[8*k +: 8] = dwd[8*(k % nb) +: 8];
      end
    end
    chk("ram_en", 32'(ram_en_o), 32'(en_e));
    chk("ram_we", 32'(ram_we_o), 32'(we_e));
    chk("ram_addr", ram_addr_o, ad_e);
    chk("ram_wdata", ram_wdata_o, wd_e);

    exp_ifv = gi; exp_ifd = 0;
    if (gi) for (int k = 0; k < 4; k++) begin
      bi = {ia[7:2], 2'b00} + 8'(k);
      exp_ifd[8*k +: 8] = mem_b[bi];
    end
    exp_dv = gd; exp_mis = gd && mis; exp_dd = 0;
    if (gd && !mis) begin
      if (dw) begin
        for (int i = 0; i < nb; i++) begin bi = da[7:0] + 8'(i); mem_b[bi] = dwd[8*i +: 8]; end
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) begin bi = da[7:0] + 8'(i); v[8*i +: 8] = mem_b[bi]; end
        if (nb == 1 && !du) v = {{24{v[7]}}, v[7:0]};
        if (nb == 2 && !du) v = {{16{v[15]}}, v[15:0]};
        exp_dd = v;
      end
    end
    if (r || gi) losses = 0;
    else if (gd && ir) losses++;
  endtask

  logic        ipend, dpend, rr, dwr, dur;
  logic [1:0]  dsr;
  logic [31:0] iar, dar, dwdr;

  initial begin
    n_assert = 0; n_fail = 0; losses = 0;
    exp_ifv = 0; exp_dv = 0; exp_mis = 0; exp_ifd = 0; exp_dd = 0; obs_d = 0;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
    tb_clr = 1'b1;
    rst_i = 1'b1; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0;
    d_size_i = 0; d_unsigned_i = 0; d_addr_i = 0; d_wdata_i = 0;

    cyc(1, 0, 0, 1, 0, 2'd2, 0, 32'h10, 0);
    cyc(1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    tb_clr = 1'b0;

    cyc(0, 0, 0, 1, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    cyc(0, 0, 0, 1, 0, 2'd2, 0, 32'h10, 0);
    cyc(0, 0, 0, 1, 0, 2'd0, 0, 32'h13, 0);
    chk("plan_word_load", obs_d, 32'hDEADBEEF);
    cyc(0, 0, 0, 1, 0, 2'd0, 1, 32'h13, 0);
    chk("plan_byte_signed", obs_d, 32'hFFFFFFDE);
    cyc(0, 0, 0, 1, 0, 2'd1, 0, 32'h12, 0);
    chk("plan_byte_unsigned", obs_d, 32'h000000DE);
    cyc(0, 0, 0, 1, 1, 2'd1, 0, 32'h22, 32'h00001234);
    chk("plan_half_signed", obs_d, 32'hFFFFDEAD);
    chk("plan_half_we", 32'(ram_we_o), 32'b0011);
    chk("plan_half_wdata", ram_wdata_o, 32'h12341234);
    cyc(0, 0, 0, 1, 0, 2'd2, 0, 32'h20, 0);
    cyc(0, 0, 0, 1, 1, 2'd0, 0, 32'h21, 32'h000000AB);
    chk("plan_half_readback", obs_d >> 16, 32'h1234);
    chk("plan_byte_we", 32'(ram_we_o), 32'b0100);
    cyc(0, 0, 0, 1, 0, 2'd2, 0, 32'h06, 0);
    chk("plan_mis_gnt", 32'(d_gnt_o), 32'd1);
    chk("plan_mis_en", 32'(ram_en_o), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("plan_mis_flag", 32'(d_misaligned_o), 32'd1);

    // Push fetch to the edge of starvation, then reset with a load response pending.
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h40, 1, 0, 2'd2, 0, 32'h10, 0);
    cyc(1, 1, 32'h40, 1, 0, 2'd2, 0, 32'h10, 0);
    chk("rst_drop_rvalid", 32'(d_rvalid_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 32'h44, 1, 0, 2'd2, 0, 32'h10, 0);
      chk("starve_pattern", 32'(d_gnt_o), 32'((i % 5) != 4));
      if (i == 0) chk("post_rst_rvalid", 32'(d_rvalid_o), 32'd0);
      if (i == 1) chk("post_rst_load", obs_d, 32'hDEADBEEF);
    end

    ipend = 0; dpend = 0; iar = 0; dar = 0; dwr = 0; dsr = 0; dur = 0; dwdr = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ipend && $urandom_range(0, 2) != 0) begin ipend = 1; iar = $urandom; end
      if (!dpend && $urandom_range(0, 2) != 0) begin
        dpend = 1; dwr = 1'($urandom_range(0, 1)); dsr = 2'($urandom_range(0, 3));
        dur = 1'($urandom_range(0, 1)); dar = $urandom; dwdr = $urandom;
      end
      rr = ($urandom_range(0, 99) == 0);
      cyc(rr, ipend, iar, dpend, dwr, dsr, dur, dar, dwdr);
      if (if_gnt_o) ipend = 0;
      if (d_gnt_o)  dpend = 0;
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
